prog_freq_div_g2: RTL and testbench
===================================

PROG_FREQ_DIV_G2 -- requirements
Module: prog_freq_div_g2

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of divisor ports and registers.
REQ-002 SHALL have parameter DIV_INIT, default 2, active divisor after reset; legal range 2..2^DIV_W-1.
REQ-003 SHALL have port CLK_in, input, 1, the single clock; all state changes on its rising edge except REQ-024.
REQ-004 SHALL have port RST, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port SYNC, input, 1, run enable; low holds the divider at period end.
REQ-006 SHALL have port DIV_IN, input, DIV_W, requested divisor N.
REQ-007 SHALL have port DIV_LD, input, 1, one-cycle load strobe qualifying DIV_IN.
REQ-008 SHALL have port CLK_out, output, 1, divided clock.
REQ-009 SHALL have port TICK, output, 1, one-cycle pulse in the first CLK_in cycle of each output period.
REQ-010 SHALL have port DIV_CUR, output, DIV_W, divisor currently in effect.
REQ-011 SHALL have port PEND, output, 1, a loaded divisor awaits application.
REQ-012 SHALL have port ERR, output, 1, one-cycle pulse on a rejected load.

Function
REQ-013 SHALL keep an internal count k running 0..N-1, incrementing once per CLK_in rising edge while SYNC=1, wrapping N-1 -> 0.
REQ-014 SHALL drive CLK_out registered: in the cycle where count equals k, CLK_out=1 if k<H, else 0, with H=ceil(N/2) (even N: 50% duty; odd N: high (N+1)/2, low (N-1)/2 cycles).
REQ-015 SHALL assert TICK exactly in the cycles where k=0.
REQ-016 SHALL, while SYNC=0 at a rising edge, force k=N-1, CLK_out=0, TICK=0; the first edge with SYNC=1 starts a period at k=0.
REQ-017 SHALL, on DIV_LD=1 with DIV_IN>=2, capture DIV_IN into a pending register and set PEND=1 at that edge.
REQ-018 SHALL, on DIV_LD=1 with DIV_IN<2, leave pending state unchanged and pulse ERR for one cycle.
REQ-019 SHALL apply the pending divisor (DIV_CUR updates, PEND clears) at the edge where k wraps N-1 -> 0, so the new period uses the new N; no period is ever truncated.
REQ-020 SHALL apply a pending divisor at the next edge when SYNC=0, leaving k=new N-1.
REQ-021 SHALL, when DIV_LD coincides with a wrap edge, apply any earlier pending value at that wrap and hold the new value pending until the following wrap.
REQ-022 SHALL let a second valid load while PEND=1 overwrite the pending value (last load wins).

Reset
REQ-023 SHALL, while RST=0, asynchronously set k=DIV_INIT-1, DIV_CUR=DIV_INIT, CLK_out=0, TICK=0, PEND=0, ERR=0, pending register=DIV_INIT; first edge after release with SYNC=1 gives k=0, CLK_out=1, TICK=1.

Configuration
REQ-024 SHALL, with macro FREQDIV_G2_ODD_BAL_EN defined, add a falling-edge register sampling the high-phase register (async-cleared by RST), and for odd N drive CLK_out as the AND of both, giving high time exactly N/2 CLK_in periods (true 50% duty).
REQ-025 SHALL, without FREQDIV_G2_ODD_BAL_EN, contain no falling-edge logic and follow REQ-014 for all N; even-N behaviour is identical in both builds.

Verification
REQ-026 SHALL verify reset: RST=0 mid-period with N=5 -> CLK_out=0, TICK=0, PEND=0, DIV_CUR=DIV_INIT immediately, without a clock edge.
REQ-027 SHALL verify ratios: N=2,3,6,23 with SYNC=1 -> CLK_out high 1/2/3/12 cycles, low 1/1/3/11 cycles, one TICK per period.
REQ-028 SHALL verify reload: running N=4, load 7 at k=1 -> PEND=1, current period completes with 4 cycles, next periods 7 cycles, PEND clears at wrap.
REQ-029 SHALL verify rejection: DIV_LD with DIV_IN=0 and with DIV_IN=1 -> ERR one cycle each, DIV_CUR and PEND unchanged.
REQ-030 SHALL verify SYNC: drop SYNC at k=2 of N=6 for 3 cycles -> CLK_out=0 held; on release, TICK=1 and CLK_out=1 on the first edge.
REQ-031 SHALL verify odd balance: FREQDIV_G2_ODD_BAL_EN defined, N=5 -> CLK_out high 2.5 and low 2.5 CLK_in periods.

Source files
------------

// File: rtl/prog_freq_div_g2.sv
// prog_freq_div_g2 : programmable integer clock divider with glitch-free
// divisor reload. The divisor changes only at a period boundary (or
// immediately while SYNC holds the divider idle), so no output period is
// ever truncated.
//
// Optional feature: define FREQDIV_G2_ODD_BAL_EN to add a falling-edge
// stage that trims the high phase of odd divisors to exactly N/2 input
// periods (true 50% duty). Without the macro the design has no
// falling-edge logic.
//
// Load interface: DIV_LD is a single-cycle strobe qualifying DIV_IN. There
// is no ready signal; every strobe is consumed at the edge where it is
// seen. A value >= 2 is accepted into the pending register, while a value
// < 2 is rejected and answered with a one-cycle ERR pulse.
module prog_freq_div_g2 #(
  parameter int DIV_W    = 8,
  parameter int DIV_INIT = 2
) (
  input  logic             CLK_in,
  input  logic             RST,
  input  logic             SYNC,
  input  logic [DIV_W-1:0] DIV_IN,
  input  logic             DIV_LD,
  output logic             CLK_out,
  output logic             TICK,
  output logic [DIV_W-1:0] DIV_CUR,
  output logic             PEND,
  output logic             ERR
);

  localparam logic [DIV_W-1:0] INIT_N = DIV_W'(DIV_INIT);
  localparam logic [DIV_W-1:0] ONE    = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO    = DIV_W'(2);

  logic [DIV_W-1:0] k;
  logic [DIV_W-1:0] cur;
  logic [DIV_W-1:0] pend_val;
  logic             pend;
  logic             clk_hi;
  logic             tick_q;
  logic             err_q;

  logic             load_ok;
  logic             load_bad;
  logic             wrap;
  logic             apply;
  logic [DIV_W-1:0] n_eff;
  logic [DIV_W:0]   half_wide;
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] k_nxt;
  logic             hi_nxt;

  // Next-state decode: a wrap ends the period, and the pending divisor
  // takes effect at a wrap or at any edge while SYNC holds the divider idle.
  always_comb begin
    load_ok   = DIV_LD && (DIV_IN >= TWO);
    load_bad  = DIV_LD && (DIV_IN < TWO);
    wrap      = SYNC && (k == (cur - ONE));
    apply     = pend && (wrap || !SYNC);
    n_eff     = apply ? pend_val : cur;
    // ceil(N/2), computed one bit wider so N = 2^DIV_W-1 does not overflow
    half_wide = ({1'b0, n_eff} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    half      = half_wide[DIV_W-1:0];
    k_nxt     = k + ONE;
    if (!SYNC) begin
      k_nxt = n_eff - ONE;
    end else if (wrap) begin
      k_nxt = '0;
    end
    hi_nxt = SYNC && (k_nxt < half);
  end

  // Count, divisor and output registers; reset parks k at the last count
  // so the first enabled edge starts a fresh period.
  always_ff @(posedge CLK_in or negedge RST) begin
    if (!RST) begin
      k        <= INIT_N - ONE;
      cur      <= INIT_N;
      pend_val <= INIT_N;
      pend     <= 1'b0;
      clk_hi   <= 1'b0;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      k      <= k_nxt;
      cur    <= n_eff;
      clk_hi <= hi_nxt;
      tick_q <= SYNC && (k_nxt == '0);
      err_q  <= load_bad;
      if (load_ok) begin
        // a load on an apply edge stays pending for the following apply
        pend_val <= DIV_IN;
        pend     <= 1'b1;
      end else if (apply) begin
        pend     <= 1'b0;
      end
    end
  end

`ifdef FREQDIV_G2_ODD_BAL_EN
  logic hi_neg;

  // Half-cycle delayed copy of the high phase; ANDing it in delays the
  // rising edge by half an input period for odd divisors.
  always_ff @(negedge CLK_in or negedge RST) begin
    if (!RST) begin
      hi_neg <= 1'b0;
    end else begin
      hi_neg <= clk_hi;
    end
  end

  assign CLK_out = cur[0] ? (clk_hi & hi_neg) : clk_hi;
`else
  assign CLK_out = clk_hi;
`endif

  assign TICK    = tick_q;
  assign DIV_CUR = cur;
  assign PEND    = pend;
  assign ERR     = err_q;

endmodule

// File: tb/tb_prog_freq_div_g2.sv
// tb_prog_freq_div_g2 : directed self-checking bench for prog_freq_div_g2
// (DIV_W=8, DIV_INIT=2). Outputs are sampled 1 time unit after the rising
// edge of CLK_in.
module tb_prog_freq_div_g2;

  logic       CLK_in;
  logic       RST;
  logic       SYNC;
  logic [7:0] DIV_IN;
  logic       DIV_LD;
  logic       CLK_out;
  logic       TICK;
  logic [7:0] DIV_CUR;
  logic       PEND;
  logic       ERR;

  int n_assert = 0;
  int n_fail   = 0;

  prog_freq_div_g2 #(.DIV_W(8), .DIV_INIT(2)) dut (
    .CLK_in (CLK_in),
    .RST    (RST),
    .SYNC   (SYNC),
    .DIV_IN (DIV_IN),
    .DIV_LD (DIV_LD),
    .CLK_out(CLK_out),
    .TICK   (TICK),
    .DIV_CUR(DIV_CUR),
    .PEND   (PEND),
    .ERR    (ERR)
  );

  // clock: period 10, rising edges at 5, 15, 25, ...
  initial CLK_in = 1'b0;
  always #5 CLK_in = ~CLK_in;

  task automatic step();
    @(posedge CLK_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected CLK_out just after the edge that makes the count equal i,
  // with h = ceil(n/2) supplied by the caller
  function automatic logic exp_clk(input int n, input int h, input int i);
`ifdef FREQDIV_G2_ODD_BAL_EN
    if ((n % 2 == 1) && (i == 0)) return 1'b0;
`endif
    return (i < h);
  endfunction

  // entered at the k=0 sample; checks one full period, ends at next k=0
  task automatic run_period(input int n, input int h);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("clk_out n=%0d k=%0d", n, i), CLK_out, exp_clk(n, h, i));
      chk($sformatf("tick n=%0d k=%0d", n, i), TICK, (i == 0));
      step();
    end
  endtask

  // entered at the k=0 sample of a period of length cur_n; loads val and
  // follows the period to the wrap that applies it
  task automatic load_and_wrap(input int val, input int cur_n);
    DIV_LD = 1'b1;
    DIV_IN = 8'(val);
    step();
    DIV_LD = 1'b0;
    chk($sformatf("pend after load %0d", val), PEND, 1);
    chk($sformatf("cur held load %0d", val), DIV_CUR, cur_n);
    repeat (cur_n - 1) step();
    chk($sformatf("cur applied %0d", val), DIV_CUR, val);
    chk($sformatf("pend clear %0d", val), PEND, 0);
    chk($sformatf("tick at wrap %0d", val), TICK, 1);
  endtask

  initial begin
    RST    = 1'b0;
    SYNC   = 1'b0;
    DIV_IN = 8'd0;
    DIV_LD = 1'b0;

    // reset state
    #12;
    chk("rst clk_out", CLK_out, 0);
    chk("rst tick", TICK, 0);
    chk("rst pend", PEND, 0);
    chk("rst err", ERR, 0);
    chk("rst div_cur", DIV_CUR, 2);

    // release: first enabled edge starts a period
    #1;
    RST  = 1'b1;
    SYNC = 1'b1;
    step();
    chk("first edge tick", TICK, 1);
    chk("first edge clk_out", CLK_out, 1);

    // ratios: N=2, 3, 6, 23
    run_period(2, 1);
    run_period(2, 1);
    load_and_wrap(3, 2);
    run_period(3, 2);
    run_period(3, 2);
    load_and_wrap(6, 3);
    run_period(6, 3);
    run_period(6, 3);
    load_and_wrap(23, 6);
    run_period(23, 12);
    load_and_wrap(4, 23);
    run_period(4, 2);

    // reload 7 at k=1 of N=4: current period keeps its 4 cycles
    step();
    DIV_LD = 1'b1;
    DIV_IN = 8'd7;
    step();
    DIV_LD = 1'b0;
    chk("reload pend k2", PEND, 1);
    chk("reload cur k2", DIV_CUR, 4);
    chk("reload clk k2", CLK_out, 0);
    step();
    chk("reload pend k3", PEND, 1);
    chk("reload tick k3", TICK, 0);
    chk("reload clk k3", CLK_out, 0);
    step();
    chk("reload wrap tick", TICK, 1);
    chk("reload wrap cur", DIV_CUR, 7);
    chk("reload wrap pend", PEND, 0);
    chk("reload wrap clk", CLK_out, exp_clk(7, 4, 0));
    run_period(7, 4);
    run_period(7, 4);

    // rejection of DIV_IN=0 and DIV_IN=1
    DIV_LD = 1'b1;
    DIV_IN = 8'd0;
    step();
    DIV_LD = 1'b0;
    chk("rej0 err", ERR, 1);
    chk("rej0 pend", PEND, 0);
    chk("rej0 cur", DIV_CUR, 7);
    step();
    chk("rej0 err drop", ERR, 0);
    DIV_LD = 1'b1;
    DIV_IN = 8'd1;
    step();
    DIV_LD = 1'b0;
    chk("rej1 err", ERR, 1);
    chk("rej1 pend", PEND, 0);
    chk("rej1 cur", DIV_CUR, 7);
    step();
    chk("rej1 err drop", ERR, 0);
    repeat (3) step();
    chk("rej period tick", TICK, 1);
    chk("rej period cur", DIV_CUR, 7);

    // last valid load wins; a rejected load leaves pending untouched
    DIV_LD = 1'b1;
    DIV_IN = 8'd5;
    step();
    DIV_IN = 8'd6;
    step();
    DIV_IN = 8'd1;
    step();
    DIV_LD = 1'b0;
    chk("lw err", ERR, 1);
    chk("lw pend", PEND, 1);
    chk("lw cur", DIV_CUR, 7);
    repeat (4) step();
    chk("lw applied cur", DIV_CUR, 6);
    chk("lw applied pend", PEND, 0);
    chk("lw applied tick", TICK, 1);

    // SYNC dropped at k=2 of N=6 for three edges
    step();
    step();
    chk("sync k2 clk", CLK_out, 1);
    SYNC = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("sync hold clk %0d", i), CLK_out, 0);
      chk($sformatf("sync hold tick %0d", i), TICK, 0);
    end
    SYNC = 1'b1;
    step();
    chk("sync release tick", TICK, 1);
    chk("sync release clk", CLK_out, 1);
    run_period(6, 3);

    // pending divisor applied while SYNC is low
    SYNC   = 1'b0;
    DIV_LD = 1'b1;
    DIV_IN = 8'd5;
    step();
    DIV_LD = 1'b0;
    chk("idle load pend", PEND, 1);
    chk("idle load cur", DIV_CUR, 6);
    chk("idle load clk", CLK_out, 0);
    step();
    chk("idle apply pend", PEND, 0);
    chk("idle apply cur", DIV_CUR, 5);
    chk("idle apply tick", TICK, 0);
    SYNC = 1'b1;
    step();
    chk("idle restart tick", TICK, 1);

`ifdef FREQDIV_G2_ODD_BAL_EN
    // N=5 balanced: high for half-samples 1..5 of the 10 in one period
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bal pos k=%0d", c), CLK_out, ((2 * c) >= 1) && ((2 * c) <= 5));
      @(negedge CLK_in);
      #1;
      chk($sformatf("bal neg k=%0d", c), CLK_out, ((2 * c + 1) >= 1) && ((2 * c + 1) <= 5));
      step();
    end
`endif
    run_period(5, 3);

    // asynchronous reset mid-period of N=5 with a load pending
    DIV_LD = 1'b1;
    DIV_IN = 8'd9;
    step();
    DIV_LD = 1'b0;
    step();
    chk("mid pend", PEND, 1);
    chk("mid clk", CLK_out, exp_clk(5, 3, 2));
    #2;
    RST = 1'b0;
    #1;
    chk("async rst clk", CLK_out, 0);
    chk("async rst tick", TICK, 0);
    chk("async rst pend", PEND, 0);
    chk("async rst cur", DIV_CUR, 2);
    #1;
    RST = 1'b1;
    step();
    chk("post rst tick", TICK, 1);
    chk("post rst clk", CLK_out, 1);
    chk("post rst cur", DIV_CUR, 2);
    chk("post rst pend", PEND, 0);
    step();
    chk("post rst k1 tick", TICK, 0);
    chk("post rst k1 clk", CLK_out, 0);
    step();
    chk("post rst wrap tick", TICK, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
